// File: rtl/logic_axi4_stream_packet_arbiter_if.sv
// Bundle of the INPUTS rx streams and the merged tx stream seen by the packet arbiter.
// The master modport is the arbiter itself; the slave modport is the surrounding environment.
interface logic_axi4_stream_packet_arbiter_if #(
  parameter int INPUTS    = 4,
  parameter int WIDTH     = 8,
  parameter int TID_WIDTH = $clog2(INPUTS)
);
  logic [INPUTS-1:0]       rx_tvalid;
  logic [INPUTS-1:0]       rx_tready;
  logic [INPUTS-1:0]       rx_tlast;
  logic [INPUTS*WIDTH-1:0] rx_tdata;
  logic                    tx_tvalid;
  logic                    tx_tready;
  logic                    tx_tlast;
  logic [WIDTH-1:0]        tx_tdata;
  logic [TID_WIDTH-1:0]    tx_tid;

  modport master (
    input  rx_tvalid, rx_tlast, rx_tdata, tx_tready,
    output rx_tready, tx_tvalid, tx_tlast, tx_tdata, tx_tid
  );

  modport slave (
    output rx_tvalid, rx_tlast, rx_tdata, tx_tready,
    input  rx_tready, tx_tvalid, tx_tlast, tx_tdata, tx_tid
  );
endinterface

// File: rtl/logic_axi4_stream_packet_arbiter.sv
// Round-robin, packet-locked AXI4-Stream arbiter; the granted source index is emitted on tx_tid.
// Define LOGIC_AXI4_STREAM_PACKET_ARBITER_OUTPUT_REGISTER_EN to drive tx_* from a 2-entry skid slice.
module logic_axi4_stream_packet_arbiter #(
  parameter int INPUTS    = 4,
  parameter int WIDTH     = 8,
  parameter int TID_WIDTH = $clog2(INPUTS)
) (
  input logic                                aclk,
  input logic                                areset_n,
  logic_axi4_stream_packet_arbiter_if.master bus
);
  typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_GRANTED = 1'b1} state_e;

  state_e               state_q;
  logic [TID_WIDTH-1:0] grant_q;
  logic [TID_WIDTH-1:0] ptr_q;
  logic                 pick_found_s;
  logic [TID_WIDTH-1:0] pick_idx_s;
  logic [TID_WIDTH:0]   cand_s;
  logic                 granted_s;
  logic                 src_valid_s;
  logic                 src_last_s;
  logic [WIDTH-1:0]     src_data_s;
  logic                 ready_g_s;
  logic                 acc_s;

  // Round-robin search: descending scan so the lowest offset from the pointer wins.
  always_comb begin
    pick_found_s = 1'b0;
    pick_idx_s   = '0;
    cand_s       = '0;
    for (int k = INPUTS - 1; k >= 0; k--) begin
      cand_s       = {1'b0, ptr_q} + (TID_WIDTH+1)'(k);
      cand_s       = (cand_s >= (TID_WIDTH+1)'(INPUTS)) ? cand_s - (TID_WIDTH+1)'(INPUTS) : cand_s;
      pick_found_s = pick_found_s | bus.rx_tvalid[cand_s[TID_WIDTH-1:0]];
      pick_idx_s   = bus.rx_tvalid[cand_s[TID_WIDTH-1:0]] ? cand_s[TID_WIDTH-1:0] : pick_idx_s;
    end
  end

  assign granted_s   = (state_q == ST_GRANTED);
  assign src_valid_s = bus.rx_tvalid[grant_q];
  assign src_last_s  = bus.rx_tlast[grant_q];
  assign src_data_s  = bus.rx_tdata[int'(grant_q) * WIDTH +: WIDTH];
  assign acc_s       = granted_s & src_valid_s & ready_g_s;

  // Grant FSM: one arbitration cycle in IDLE, grant locked until the tlast beat is accepted.
  always_ff @(posedge aclk or negedge areset_n) begin
    if (!areset_n) begin
      state_q <= ST_IDLE;
      grant_q <= '0;
      ptr_q   <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (pick_found_s) begin
            grant_q <= pick_idx_s;
            state_q <= ST_GRANTED;
          end
        end
        ST_GRANTED: begin
          if (acc_s && src_last_s) begin
            ptr_q   <= (grant_q == TID_WIDTH'(INPUTS - 1)) ? '0 : grant_q + TID_WIDTH'(1);
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Only the granted source ever sees ready.
  always_comb begin
    bus.rx_tready = '0;
    if (granted_s) begin
      bus.rx_tready[grant_q] = ready_g_s;
    end else begin
      bus.rx_tready = '0;
    end
  end

`ifdef LOGIC_AXI4_STREAM_PACKET_ARBITER_OUTPUT_REGISTER_EN
  logic [WIDTH-1:0]     slot_data_q [2];
  logic                 slot_last_q [2];
  logic [TID_WIDTH-1:0] slot_tid_q  [2];
  logic                 wr_q;
  logic                 rd_q;
  logic [1:0]           cnt_q;
  logic                 pop_s;

  // Ready depends only on slice occupancy, cutting the tx_tready -> rx_tready path.
  assign ready_g_s = (cnt_q != 2'd2);
  assign pop_s     = bus.tx_tvalid & bus.tx_tready;

  // Two-entry skid slice holding accepted beats with their source index.
  always_ff @(posedge aclk or negedge areset_n) begin
    if (!areset_n) begin
      for (int e = 0; e < 2; e++) begin
        slot_data_q[e] <= '0;
        slot_last_q[e] <= 1'b0;
        slot_tid_q[e]  <= '0;
      end
      wr_q  <= 1'b0;
      rd_q  <= 1'b0;
      cnt_q <= 2'd0;
    end else begin
      if (acc_s) begin
        slot_data_q[wr_q] <= src_data_s;
        slot_last_q[wr_q] <= src_last_s;
        slot_tid_q[wr_q]  <= grant_q;
        wr_q              <= ~wr_q;
      end
      if (pop_s) begin
        rd_q <= ~rd_q;
      end
      cnt_q <= cnt_q + {1'b0, acc_s} - {1'b0, pop_s};
    end
  end

  // Empty slice presents all-zero outputs.
  always_comb begin
    bus.tx_tvalid = (cnt_q != 2'd0);
    if (bus.tx_tvalid) begin
      bus.tx_tdata = slot_data_q[rd_q];
      bus.tx_tlast = slot_last_q[rd_q];
      bus.tx_tid   = slot_tid_q[rd_q];
    end else begin
      bus.tx_tdata = '0;
      bus.tx_tlast = 1'b0;
      bus.tx_tid   = '0;
    end
  end
`else
  assign ready_g_s = bus.tx_tready;

  // Combinational pass-through of the granted source.
  always_comb begin
    if (granted_s) begin
      bus.tx_tvalid = src_valid_s;
      bus.tx_tdata  = src_data_s;
      bus.tx_tlast  = src_last_s;
      bus.tx_tid    = grant_q;
    end else begin
      bus.tx_tvalid = 1'b0;
      bus.tx_tdata  = '0;
      bus.tx_tlast  = 1'b0;
      bus.tx_tid    = '0;
    end
  end
`endif
endmodule
